// File: rtl/jtkcpu_muldiv.sv
// jtkcpu_muldiv - iterative multiply/divide unit for the KCPU ALU path.
// Handles one operation at a time and produces one result bit per enabled clock.
//   mode 0 = MULU, 1 = MULS  : W x W multiply, 2W product
//   mode 2 = DIVU, 3 = DIVS  : 2W / W restoring divide, W quotient + W remainder
// Ports:
//   clk, rst (async, active-low), cen (clock enable for all state)
//   start/mode/opnd0/opnd1 : request and operands, latched when idle
//   busy, done             : operation in progress / one-cycle completion pulse
//   rslt_lo, rslt_hi       : product low/high, or quotient/remainder
//   flags                  : {N,Z,V,C}
// Latency is fixed: start accepted at enabled edge k, done high after edge k+W+2.
module jtkcpu_muldiv #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [2*W-1:0] opnd0,
    input  logic [W-1:0]   opnd1,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   rslt_lo,
    output logic [W-1:0]   rslt_hi,
    output logic [3:0]     flags
);

    localparam int unsigned   CW   = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t         r_state, w_state_nx;
    logic [1:0]     r_mode;
    logic [2*W-1:0] r_a;        // latched opnd0, returned unchanged on overflow
    logic [W-1:0]   r_b;        // latched opnd1, replaced by its magnitude in PREP
    logic [W-1:0]   r_m;        // multiplicand magnitude
    logic [2*W-1:0] r_p;        // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [CW-1:0]  r_cnt;
    logic           r_neg_q;    // negate product / quotient in FIX
    logic           r_neg_r;    // negate remainder in FIX
    logic           r_dz;
    logic           r_ovf;

    logic           w_div, w_sgn;
    logic           w_mc_neg, w_b_neg, w_dd_neg;
    logic [W-1:0]   w_mc_abs, w_b_abs;
    logic [2*W-1:0] w_dd_abs;
    logic           w_ovf_pre;
    logic [W:0]     w_sum;
    logic [2*W:0]   w_sh;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_p_step;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_q, w_r, w_q_s, w_r_s;
    logic           w_ovf_s;
    logic [W-1:0]   w_lo_fix, w_hi_fix;
    logic [3:0]     w_flags_fix;

    assign w_div = r_mode[1];
    assign w_sgn = r_mode[0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (cen) begin
            case (r_state)
                S_IDLE:  if (start) w_state_nx = S_PREP;
                S_PREP:  w_state_nx = S_RUN;
                S_RUN:   if (r_cnt == LAST) w_state_nx = S_FIX;
                S_FIX:   w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // ---------------- PREP: magnitudes and signs ----------------
    always_comb begin
        w_mc_neg  = w_sgn & r_a[W-1];
        w_b_neg   = w_sgn & r_b[W-1];
        w_dd_neg  = w_sgn & r_a[2*W-1];
        w_mc_abs  = w_mc_neg ? -r_a[W-1:0] : r_a[W-1:0];
        w_b_abs   = w_b_neg  ? -r_b        : r_b;
        w_dd_abs  = w_dd_neg ? -r_a        : r_a;
        // Quotient magnitude needs more than W bits when the high half already
        // reaches the divisor; this also catches divide-by-zero.
        w_ovf_pre = (w_dd_abs[2*W-1:W] >= w_b_abs);
    end

    // ---------------- RUN: one iteration ----------------
    always_comb begin
        w_sum  = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_m} : '0);
        w_sh   = {r_p, 1'b0};
        // Remainder stays below the divisor, so the shifted top fits in W+1 bits
        // and bit W of the difference is the borrow.
        w_diff = w_sh[2*W:W] - {1'b0, r_b};
        if (!w_div)
            w_p_step = {w_sum, r_p[W-1:1]};
        else if (!w_diff[W])
            w_p_step = {w_diff[W-1:0], w_sh[W-1:1], 1'b1};
        else
            w_p_step = w_sh[2*W-1:0];
    end

    // ---------------- FIX: signs, overflow, flags ----------------
    always_comb begin
        w_prod  = r_neg_q ? -r_p : r_p;
        w_q     = r_p[W-1:0];
        w_r     = r_p[2*W-1:W];
        w_q_s   = r_neg_q ? -w_q : w_q;
        w_r_s   = r_neg_r ? -w_r : w_r;
        // Negative quotients may reach -2^(W-1); positive ones stop at 2^(W-1)-1.
        w_ovf_s = w_sgn & (r_neg_q ? (w_q[W-1] & (|w_q[W-2:0])) : w_q[W-1]);

        w_lo_fix    = w_q_s;
        w_hi_fix    = w_r_s;
        w_flags_fix = {w_q_s[W-1], (w_q_s == '0), 1'b0, w_q_s[0]};
        if (!w_div) begin
            w_lo_fix    = w_prod[W-1:0];
            w_hi_fix    = w_prod[2*W-1:W];
            w_flags_fix = {w_prod[2*W-1], (w_prod == '0), 1'b0, w_prod[W-1]};
        end else if (r_dz) begin
            w_lo_fix    = r_a[W-1:0];
            w_hi_fix    = r_a[2*W-1:W];
            w_flags_fix = 4'b0110;
        end else if (r_ovf || w_ovf_s) begin
            w_lo_fix    = r_a[W-1:0];
            w_hi_fix    = r_a[2*W-1:W];
            w_flags_fix = 4'b0010;
        end
    end

    // ---------------- datapath and outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rslt_lo <= '0;
            rslt_hi <= '0;
            flags   <= '0;
        end else if (cen) begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_a    <= opnd0;
                        r_b    <= opnd1;
                        busy   <= 1'b1;
                    end
                end
                S_PREP: begin
                    r_cnt <= '0;
                    r_b   <= w_b_abs;
                    r_dz  <= w_div & (r_b == '0);
                    r_ovf <= w_div & w_ovf_pre;
                    if (w_div) begin
                        r_p     <= w_dd_abs;
                        r_neg_q <= w_dd_neg ^ w_b_neg;
                        r_neg_r <= w_dd_neg;
                    end else begin
                        r_p     <= {{W{1'b0}}, w_b_abs};
                        r_m     <= w_mc_abs;
                        r_neg_q <= w_mc_neg ^ w_b_neg;
                        r_neg_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_p   <= w_p_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    rslt_lo <= w_lo_fix;
                    rslt_hi <= w_hi_fix;
                    flags   <= w_flags_fix;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
